dsp_addr_ctrl: RTL and testbench

- Sequencer directly upstream of the 4-stage write-control delay line (pipeline_reg).
- On a start pulse it streams read addresses to BRAM0, which feeds the DSP datapath, one per cycle.
- It generates the matching BRAM1 write-enable/write-address pair, aligned with BRAM0 read data, and hands that pair to the delay line.
- It pulses done once the last result has committed to BRAM1.

---
 rtl/dsp_addr_ctrl_pkg.sv | 17 +
 rtl/dsp_addr_ctrl.sv | 138 +++++++++++++
 tb/tb_dsp_addr_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_addr_ctrl_pkg.sv
// Shared definitions for the BRAM0 read / BRAM1 write address sequencer.
package dsp_addr_ctrl_pkg;

  // Default BRAM address width.
  localparam int ADDR_WIDTH_DEF = 5;
  // Default number of delay-line stages between the sequencer and the BRAM1 write port.
  localparam int PIPE_DEPTH_DEF = 4;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dsp_addr_ctrl.sv
// Address sequencer: streams BRAM0 read addresses, produces the BRAM1 write
// strobe/address one cycle later (BRAM0 read latency), waits for the external
// write delay line to drain and then pulses done.
module dsp_addr_ctrl
  import dsp_addr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  bram0_en_o,
  output logic [ADDR_WIDTH-1:0] bram0_r_addr_o,
  output logic                  bram1_web_o,
  output logic [ADDR_WIDTH-1:0] bram1_w_addr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Counter one bit wider than the address so a full 2^ADDR_WIDTH transfer never wraps.
  localparam int CW = ADDR_WIDTH + 1;
  // Drain counter must hold 0..PIPE_DEPTH.
  localparam int DW = $clog2(PIPE_DEPTH + 2);

  state_e                state_q, state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state, counter and output computation.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    len_d    = len_q;
    drain_d  = drain_q;
    en_d     = 1'b0;
    raddr_d  = raddr_q;
    // Alignment register: the write pair trails the read pair by the BRAM0 latency.
    // raddr holds during bubbles, so waddr also holds whenever web is low.
    web_d    = en_q;
    waddr_d  = raddr_q;
    done_d   = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != {CW{1'b0}}) begin
            len_d    = len_i;
            rd_cnt_d = {CW{1'b0}};
            state_d  = ST_READ;
          end else begin
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!stall_i) begin
          en_d     = 1'b1;
          raddr_d  = rd_cnt_q[ADDR_WIDTH-1:0];
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == (len_q - CW'(1))) begin
            drain_d = {DW{1'b0}};
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          en_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // One cycle for the alignment register plus PIPE_DEPTH for the delay line.
        if (drain_q == DW'(PIPE_DEPTH)) begin
          drain_d = {DW{1'b0}};
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Busy tracks the state being entered so it rises right after the start edge
    // and is already low in the done_o cycle.
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs; reset aborts any transfer at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= {CW{1'b0}};
      len_q    <= {CW{1'b0}};
      drain_q  <= {DW{1'b0}};
      en_q     <= 1'b0;
      raddr_q  <= {ADDR_WIDTH{1'b0}};
      web_q    <= 1'b0;
      waddr_q  <= {ADDR_WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      len_q    <= len_d;
      drain_q  <= drain_d;
      en_q     <= en_d;
      raddr_q  <= raddr_d;
      web_q    <= web_d;
      waddr_q  <= waddr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bram0_en_o     = en_q;
  assign bram0_r_addr_o = raddr_q;
  assign bram1_web_o    = web_q;
  assign bram1_w_addr_o = waddr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_dsp_addr_ctrl.sv
// Scoreboard bench for dsp_addr_ctrl: the driver predicts every read, write and
// done event (edge number + address) from its own stimulus; a negedge monitor
// pops and compares them as the DUT produces them.
module tb_dsp_addr_ctrl;

  localparam int AW = 5;
  localparam int PD = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [AW:0]   len_i = '0;
  logic          bram0_en_o;
  logic [AW-1:0] bram0_r_addr_o;
  logic          bram1_web_o;
  logic [AW-1:0] bram1_w_addr_o;
  logic          busy_o;
  logic          done_o;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int wr_addr_q[$];
  int wr_cyc_q[$];
  int done_q[$];
  int last_rd = 0;
  int last_wr = 0;
  int busy_lo = 0;
  int busy_hi = 0;

  dsp_addr_ctrl #(.ADDR_WIDTH(AW), .PIPE_DEPTH(PD)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stall_i        (stall_i),
    .len_i          (len_i),
    .bram0_en_o     (bram0_en_o),
    .bram0_r_addr_o (bram0_r_addr_o),
    .bram1_web_o    (bram1_web_o),
    .bram1_w_addr_o (bram1_w_addr_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT activity against the predicted events.
  always @(negedge clk) begin
    int e;
    if (bram0_en_o) begin
      if (rd_addr_q.size() == 0) begin
        check("rd_extra", 32'd1, 32'd0);
      end else begin
        e = rd_addr_q.pop_front();
        last_rd = e;
        check("rd_addr", 32'(bram0_r_addr_o), e);
        check("rd_cyc", cyc, rd_cyc_q.pop_front());
      end
    end else begin
      check("rd_hold", 32'(bram0_r_addr_o), last_rd);
      if (rd_cyc_q.size() > 0 && rd_cyc_q[0] <= cyc) begin
        check("rd_missing", 32'd0, 32'd1);
        void'(rd_addr_q.pop_front());
        void'(rd_cyc_q.pop_front());
      end
    end

    if (bram1_web_o) begin
      if (wr_addr_q.size() == 0) begin
        check("wr_extra", 32'd1, 32'd0);
      end else begin
        e = wr_addr_q.pop_front();
        last_wr = e;
        check("wr_addr", 32'(bram1_w_addr_o), e);
        check("wr_cyc", cyc, wr_cyc_q.pop_front());
      end
    end else begin
      check("wr_hold", 32'(bram1_w_addr_o), last_wr);
      if (wr_cyc_q.size() > 0 && wr_cyc_q[0] <= cyc) begin
        check("wr_missing", 32'd0, 32'd1);
        void'(wr_addr_q.pop_front());
        void'(wr_cyc_q.pop_front());
      end
    end

    if (done_o) begin
      if (done_q.size() == 0) check("done_extra", 32'd1, 32'd0);
      else check("done_cyc", cyc, done_q.pop_front());
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      check("done_missing", 32'd0, 32'd1);
      void'(done_q.pop_front());
    end

    check("busy", 32'(busy_o), 32'((cyc >= busy_lo) && (cyc < busy_hi)));
  end

  // One transfer. mask[k] = stall_i level sampled at edge s+k (s = start edge).
  // restart_k: re-pulse start (with another len) at edge s+restart_k.
  // restart_done: pulse start in the DONE cycle. rst_k: reset after edge s+rst_k-1.
  task automatic run_xfer(input int len, input logic [63:0] mask, input int restart_k,
                          input bit restart_done, input int rst_k);
    int s, k, i, last_w, done_edge, n;
    s = cyc + 1;
    k = 1;
    i = 0;
    last_w = 0;
    while (i < len && k < 64) begin
      if (!mask[k]) begin
        rd_addr_q.push_back(i);
        rd_cyc_q.push_back(s + k);
        wr_addr_q.push_back(i);
        wr_cyc_q.push_back(s + k + 1);
        last_w = s + k + 1;
        i++;
      end
      k++;
    end
    done_edge = (len == 0) ? s + 1 : last_w + PD + 1;
    if (rst_k == 0) done_q.push_back(done_edge);
    busy_lo = s;
    busy_hi = done_edge;

    start_i = 1'b1;
    len_i   = len[AW:0];
    stall_i = mask[0];
    n = done_edge - s + 3;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      stall_i = (j < 64) ? mask[j] : 1'b0;
      if (j == restart_k) begin
        start_i = 1'b1;
        len_i   = 6'd2;
      end
      if (restart_done && (s + j == done_edge)) start_i = 1'b1;
      if (j == rst_k) begin
        @(negedge clk); #1;
        rst_i = 1'b1;
        #1;
        check("rst_en", 32'(bram0_en_o), 32'd0);
        check("rst_raddr", 32'(bram0_r_addr_o), 32'd0);
        check("rst_web", 32'(bram1_web_o), 32'd0);
        check("rst_waddr", 32'(bram1_w_addr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        wr_cyc_q.delete();
        done_q.delete();
        busy_hi = 0;
        last_rd = 0;
        last_wr = 0;
        start_i = 1'b0;
        stall_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        break;
      end
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    // Quiet period: any late or spurious read/write/done is flagged by the monitor.
    repeat (10) @(posedge clk);
    #1;
    check("rd_left", rd_addr_q.size(), 32'd0);
    check("wr_left", wr_addr_q.size(), 32'd0);
    check("done_left", done_q.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("init_en", 32'(bram0_en_o), 32'd0);
    check("init_raddr", 32'(bram0_r_addr_o), 32'd0);
    check("init_web", 32'(bram1_web_o), 32'd0);
    check("init_waddr", 32'(bram1_w_addr_o), 32'd0);
    check("init_busy", 32'(busy_o), 32'd0);
    check("init_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // len 8, no stall; stall held during the start edge must be harmless.
    run_xfer(8, 64'h1, 0, 1'b0, 0);
    // Full range: 0..31 with no wrap.
    run_xfer(32, 64'h0, 0, 1'b0, 0);
    // len 6, 2-cycle stall after the 3rd read, plus stall during drain (ignored).
    run_xfer(6, (64'h1 << 4) | (64'h1 << 5) | (64'h1 << 10) | (64'h1 << 11), 0, 1'b0, 0);
    // Zero length: done only.
    run_xfer(0, 64'h0, 0, 1'b0, 0);
    // Stall during the last read defers it.
    run_xfer(4, (64'h1 << 4) | (64'h1 << 5), 0, 1'b0, 0);
    // Start re-pulsed in READ and in the DONE cycle.
    run_xfer(5, 64'h0, 3, 1'b1, 0);
    // Reset mid-READ once address 4 is out.
    run_xfer(8, 64'h0, 0, 1'b0, 6);
    // Clean run after the abort.
    run_xfer(3, 64'h0, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
